// File: rtl/serial_adder.sv
// Multi-cycle adder: one BITS_PER_CYCLE-wide slice plus a registered carry, LSB slice first.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for a - b (carry=1 means no borrow).
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Reject configurations where the slice does not tile the operand.
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_reg_q, a_reg_d;
    logic [WIDTH-1:0]      b_reg_q, b_reg_d;
    logic [WIDTH-1:0]      psum_q,  psum_d;
    logic                  creg_q,  creg_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [WIDTH-1:0]      sum_q,   sum_d;
    logic                  carry_q, carry_d;

    logic [BITS_PER_CYCLE:0] slice;
    logic [WIDTH-1:0]        psum_next;
    logic [WIDTH-1:0]        b_load;
    logic                    c_load;

    // Operand conditioning at capture time: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // Slice adder; its low part enters the partial sum from the MSB end.
    assign slice = {1'b0, a_reg_q[BITS_PER_CYCLE-1:0]}
                 + {1'b0, b_reg_q[BITS_PER_CYCLE-1:0]}
                 + {{BITS_PER_CYCLE{1'b0}}, creg_q};

    assign psum_next = (psum_q >> BITS_PER_CYCLE)
                     | (WIDTH'(slice[BITS_PER_CYCLE-1:0]) << (WIDTH - BITS_PER_CYCLE));

    always_comb begin
        // NOTE: every variable gets a hold default first so no branch can infer a latch.
        state_d = state_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        psum_d  = psum_q;
        creg_d  = creg_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_reg_d = a;
                    b_reg_d = b_load;
                    creg_d  = c_load;
                    psum_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_reg_d = a_reg_q >> BITS_PER_CYCLE;
                b_reg_d = b_reg_q >> BITS_PER_CYCLE;
                psum_d  = psum_next;
                creg_d  = slice[BITS_PER_CYCLE];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    sum_d   = psum_next;
                    carry_d = slice[BITS_PER_CYCLE];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_reg_q <= '0;
            b_reg_q <= '0;
            psum_q  <= '0;
            creg_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            psum_q  <= psum_d;
            creg_q  <= creg_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Handshake outputs decode the state register directly, so they are glitch-free.
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: BPC=1 and BPC=4 instances, directed vectors.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0;
    logic       busy1, done1, carry1;
    logic [7:0] sum1;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, carry4;
    logic [7:0] sum4;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub1 = 1'b0;
    logic sub4 = 1'b0;
`endif

    exp_t exp1_q[$];
    exp_t exp4_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1) begin
            if (exp1_q.size() == 0) begin
                check("dut1_spurious_done", 32'(done1), 32'd0);
            end else begin
                e = exp1_q.pop_front();
                check({e.name, "_sum"},   32'(sum1),   32'(e.sum));
                check({e.name, "_carry"}, 32'(carry1), 32'(e.carry));
                check({e.name, "_busy_at_done"}, 32'(busy1), 32'd0);
            end
        end
        if (!rst && done4) begin
            if (exp4_q.size() == 0) begin
                check("dut4_spurious_done", 32'(done4), 32'd0);
            end else begin
                e = exp4_q.pop_front();
                check({e.name, "_sum"},   32'(sum4),   32'(e.sum));
                check({e.name, "_carry"}, 32'(carry4), 32'(e.carry));
            end
        end
    end

    task automatic launch(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input bit sub, input bit expect_result,
                          input logic [7:0] es, input logic ec, input string name);
        exp_t e;
        @(negedge clk);
        e.sum = es; e.carry = ec; e.name = name;
        if (sel == 1'b0) begin
            if (expect_result) exp1_q.push_back(e);
            a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            sub1 = sub;
`endif
        end else begin
            if (expect_result) exp4_q.push_back(e);
            a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            sub4 = sub;
`endif
        end
        if (sub) cin1 = 1'b0;
        @(posedge clk);
        #1;
        // Scramble inputs after capture; they must not affect the running operation.
        if (sel == 1'b0) begin
            start1 = 1'b0; a1 = 8'hA5; b1 = 8'h5A; cin1 = ~cin1;
`ifdef SERIAL_ADDER_SUB_EN
            sub1 = ~sub1;
`endif
            check({name, "_busy_after_start"}, 32'(busy1), 32'd1);
        end else begin
            start4 = 1'b0; a4 = 8'hA5; b4 = 8'h5A; cin4 = ~cin4;
`ifdef SERIAL_ADDER_SUB_EN
            sub4 = ~sub4;
`endif
            check({name, "_busy_after_start"}, 32'(busy4), 32'd1);
        end
    endtask

    // Counts negedges after the start edge until done; optionally pokes start mid-run.
    task automatic wait_done(input bit sel, input int exp_lat, input int exp_busy,
                             input int poke_at, input string name);
        int n = 0;
        int nb = 0;
        bit seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (sel ? busy4 : busy1) nb++;
            if (sel ? done4 : done1) seen = 1'b1;
            if (!sel && poke_at > 0 && n == poke_at) begin
                start1 = 1'b1; a1 = 8'h11; b1 = 8'h22;
            end else if (!sel && poke_at > 0 && n == poke_at + 1) begin
                start1 = 1'b0;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_latency"},    32'(n),  32'(exp_lat));
            check({name, "_busy_count"}, 32'(nb), 32'(exp_busy));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy",  32'(busy1),  32'd0);
        check("reset_done",  32'(done1),  32'd0);
        check("reset_sum",   32'(sum1),   32'd0);
        check("reset_carry", 32'(carry1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        launch(1'b0, 8'h35, 8'h4A, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, "add_35_4a");
        wait_done(1'b0, 9, 8, 0, "add_35_4a");

        launch(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, "add_ff_01");
        wait_done(1'b0, 9, 8, 0, "add_ff_01");
        launch(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
        wait_done(1'b0, 9, 8, 0, "add_ff_ff_c");

        // start during RUN must be ignored and not queued.
        launch(1'b0, 8'h35, 8'h4A, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, "ignore_start");
        wait_done(1'b0, 9, 8, 3, "ignore_start");
        repeat (12) @(negedge clk);
        check("ignore_start_idle_busy", 32'(busy1),  32'd0);
        check("hold_sum",               32'(sum1),   32'h7F);
        check("hold_carry",             32'(carry1), 32'd0);

        // Abort mid-RUN: no expectation pushed, so any done pulse is flagged.
        launch(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "abort");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",  32'(busy1),  32'd0);
        check("abort_done",  32'(done1),  32'd0);
        check("abort_sum",   32'(sum1),   32'd0);
        check("abort_carry", 32'(carry1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_busy", 32'(busy1), 32'd0);
        launch(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, "after_reset");
        wait_done(1'b0, 9, 8, 0, "after_reset");

        launch(1'b1, 8'hC8, 8'h64, 1'b1, 1'b0, 1'b1, 8'h2D, 1'b1, "bpc4_c8_64");
        wait_done(1'b1, 3, 2, 0, "bpc4_c8_64");

`ifdef SERIAL_ADDER_SUB_EN
        launch(1'b0, 8'h10, 8'h03, 1'b0, 1'b1, 1'b1, 8'h0D, 1'b1, "sub_10_03");
        wait_done(1'b0, 9, 8, 0, "sub_10_03");
        launch(1'b0, 8'h03, 8'h10, 1'b1, 1'b1, 1'b1, 8'hF3, 1'b0, "sub_03_10");
        wait_done(1'b0, 9, 8, 0, "sub_03_10");
        launch(1'b0, 8'h35, 8'h4A, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, "sub_off_add");
        wait_done(1'b0, 9, 8, 0, "sub_off_add");
`endif

        repeat (4) @(negedge clk);
        check("exp1_q_drained", 32'(exp1_q.size()), 32'd0);
        check("exp4_q_drained", 32'(exp4_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
